pulp_clk_gate_ctrl: RTL and testbench

PULP_CLK_GATE_CTRL -- requirements
Module: pulp_clk_gate_ctrl

---
 rtl/pulp_clk_gate_ctrl.sv | 151 +++++++++++++++
 tb/tb_pulp_clk_gate_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulp_clk_gate_ctrl.sv
// Clock-gate controller for the PULP domain: drains snooped AXI traffic before
// dropping the clock enable, and waits for the enable path to settle on each edge.
module pulp_clk_gate_ctrl #(
  parameter int unsigned CNT_WIDTH   = 4,
  parameter int unsigned SYNC_CYCLES = 8
) (
  input  logic Clk_CI,
  input  logic Rst_RBI,
  input  logic EnReq_SI,
  input  logic AxiAwValid_SI,
  input  logic AxiAwReady_SI,
  input  logic AxiBValid_SI,
  input  logic AxiBReady_SI,
  input  logic AxiArValid_SI,
  input  logic AxiArReady_SI,
  input  logic AxiRValid_SI,
  input  logic AxiRReady_SI,
  input  logic AxiRLast_SI,
  output logic ClkEn_SO,
  output logic Block_SO,
  output logic Gated_SO,
  output logic Err_SO
);

  typedef enum logic [2:0] {
    ST_ON,
    ST_DRAIN,
    ST_GATE_WAIT,
    ST_OFF,
    ST_UNGATE_WAIT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [7:0]           TIMER_LOAD = 8'(SYNC_CYCLES - 1);

  state_t               state_reg, state_next;
  logic [7:0]           timer_reg, timer_next;
  logic [CNT_WIDTH-1:0] wcnt_reg, wcnt_next;
  logic [CNT_WIDTH-1:0] rcnt_reg, rcnt_next;
  logic                 err_reg, err_next;

  logic hs_aw, hs_b, hs_ar, hs_r, hs_rlast, hs_any;
  logic block, clk_en, gated, wcnt_err, rcnt_err;
  logic [CNT_WIDTH:0] wstep, rstep;

  // Returns {saturation_error, next_count}; simultaneous inc/dec cancel out.
  function automatic logic [CNT_WIDTH:0] cnt_step(input logic [CNT_WIDTH-1:0] cnt,
                                                  input logic inc, input logic dec);
    logic [CNT_WIDTH:0] res;
    res = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == CNT_MAX) res[CNT_WIDTH] = 1'b1;
      else                res = {1'b0, cnt + 1'b1};
    end else if (dec && !inc) begin
      if (cnt == '0) res[CNT_WIDTH] = 1'b1;
      else           res = {1'b0, cnt - 1'b1};
    end
    return res;
  endfunction

  assign hs_aw    = AxiAwValid_SI & AxiAwReady_SI;
  assign hs_b     = AxiBValid_SI & AxiBReady_SI;
  assign hs_ar    = AxiArValid_SI & AxiArReady_SI;
  assign hs_r     = AxiRValid_SI & AxiRReady_SI;
  assign hs_rlast = hs_r & AxiRLast_SI;
  assign hs_any   = hs_aw | hs_b | hs_ar | hs_r;

  assign wstep     = cnt_step(wcnt_reg, hs_aw, hs_b);
  assign rstep     = cnt_step(rcnt_reg, hs_ar, hs_rlast);
  assign wcnt_next = wstep[CNT_WIDTH-1:0];
  assign rcnt_next = rstep[CNT_WIDTH-1:0];
  assign wcnt_err  = wstep[CNT_WIDTH];
  assign rcnt_err  = rstep[CNT_WIDTH];

  assign block = (state_reg != ST_ON) | (wcnt_reg == CNT_MAX) | (rcnt_reg == CNT_MAX);

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    case (state_reg)
      ST_ON: begin
        if (!EnReq_SI) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (EnReq_SI) begin
          state_next = ST_ON;
        end else if (wcnt_reg == '0 && rcnt_reg == '0) begin
          state_next = ST_GATE_WAIT;
          timer_next = TIMER_LOAD;
        end
      end
      ST_GATE_WAIT: begin
        if (timer_reg == 8'd0) state_next = ST_OFF;
        else                   timer_next = timer_reg - 8'd1;
      end
      ST_OFF: begin
        if (EnReq_SI) begin
          state_next = ST_UNGATE_WAIT;
          timer_next = TIMER_LOAD;
        end
      end
      ST_UNGATE_WAIT: begin
        if (timer_reg == 8'd0) state_next = ST_ON;
        else                   timer_next = timer_reg - 8'd1;
      end
      default: state_next = ST_ON;
    endcase
  end

  // Enable and gated status depend on the state register alone.
  always_comb begin
    clk_en = 1'b1;
    gated  = 1'b0;
    case (state_reg)
      ST_GATE_WAIT: clk_en = 1'b0;
      ST_OFF: begin
        clk_en = 1'b0;
        gated  = 1'b1;
      end
      default: ;
    endcase
  end

  // Traffic is illegal once the clock is (being) removed.
  assign err_next = err_reg
                  | ((hs_aw | hs_ar) & block)
                  | (((state_reg == ST_GATE_WAIT) | (state_reg == ST_OFF)) & hs_any)
                  | wcnt_err | rcnt_err;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_reg <= ST_ON;
      timer_reg <= 8'd0;
      wcnt_reg  <= '0;
      rcnt_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      wcnt_reg  <= wcnt_next;
      rcnt_reg  <= rcnt_next;
      err_reg   <= err_next;
    end
  end

  assign ClkEn_SO = clk_en;
  assign Gated_SO = gated;
  assign Block_SO = block;
  assign Err_SO   = err_reg;

endmodule

// File: tb/tb_pulp_clk_gate_ctrl.sv
// Bench for pulp_clk_gate_ctrl: directed latency scenarios with literal expectations
// plus randomized traffic compared every cycle against a level/settle-time model.
module tb_pulp_clk_gate_ctrl;
  localparam int CW   = 2;
  localparam int SYNC = 8;
  localparam int MAXV = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic aw_v = 0, aw_r = 0, b_v = 0, b_r = 0, ar_v = 0, ar_r = 0;
  logic r_v = 0, r_r = 0, r_l = 0;
  logic clk_en, block, gated, err;

  int n_checks = 0;
  int n_errors = 0;

  pulp_clk_gate_ctrl #(.CNT_WIDTH(CW), .SYNC_CYCLES(SYNC)) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n), .EnReq_SI(en),
    .AxiAwValid_SI(aw_v), .AxiAwReady_SI(aw_r),
    .AxiBValid_SI(b_v), .AxiBReady_SI(b_r),
    .AxiArValid_SI(ar_v), .AxiArReady_SI(ar_r),
    .AxiRValid_SI(r_v), .AxiRReady_SI(r_r), .AxiRLast_SI(r_l),
    .ClkEn_SO(clk_en), .Block_SO(block), .Gated_SO(gated), .Err_SO(err)
  );

  always #5 clk = ~clk;

  // Model: clock level, remaining settle cycles after an edge, pending drain request.
  int m_w, m_r, m_settle;
  bit m_lvl, m_drain, m_err;

  function automatic bit m_block();
    return !(m_lvl && m_settle == 0 && !m_drain) || m_w == MAXV || m_r == MAXV;
  endfunction

  task automatic chk(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_w = 0; m_r = 0; m_settle = 0; m_lvl = 1; m_drain = 0; m_err = 0;
    end else begin
      bit aw, b, ar, r, rl;
      int nw, nr;
      aw = aw_v && aw_r; b = b_v && b_r; ar = ar_v && ar_r; r = r_v && r_r; rl = r && r_l;
      if ((aw || ar) && m_block()) m_err = 1;
      if (!m_lvl && (aw || b || ar || r)) m_err = 1;
      nw = m_w + int'(aw) - int'(b);
      if (nw < 0 || nw > MAXV) begin m_err = 1; nw = m_w; end
      nr = m_r + int'(ar) - int'(rl);
      if (nr < 0 || nr > MAXV) begin m_err = 1; nr = m_r; end
      if (m_settle > 0) m_settle--;
      else if (m_lvl && m_drain) begin
        if (en) m_drain = 0;
        else if (m_w == 0 && m_r == 0) begin m_lvl = 0; m_drain = 0; m_settle = SYNC; end
      end else if (m_lvl) begin
        if (!en) m_drain = 1;
      end else if (en) begin
        m_lvl = 1; m_settle = SYNC;
      end
      m_w = nw; m_r = nr;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("model_clk_en", clk_en, m_lvl);
      chk("model_gated", gated, !m_lvl && m_settle == 0);
      chk("model_block", block, m_block());
      chk("model_err", err, m_err);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    aw_v = 0; aw_r = 0; b_v = 0; b_r = 0; ar_v = 0; ar_r = 0; r_v = 0; r_r = 0; r_l = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; idle(); step(); step(); rst_n = 1;
  endtask

  task automatic drive(input int code);
    idle();
    case (code)
      1: begin aw_v = 1; aw_r = 1; end
      2: begin b_v = 1; b_r = 1; end
      3: begin ar_v = 1; ar_r = 1; end
      4: begin r_v = 1; r_r = 1; r_l = 1; end
      default: ;
    endcase
  endtask

  int drain_seq[8] = '{2, 0, 4, 2, 0, 4, 0, 2};

  initial begin
    idle();
    step(); step();
    chk("reset_clk_en", clk_en, 1'b1);
    chk("reset_block", block, 1'b0);
    chk("reset_gated", gated, 1'b0);
    chk("reset_err", err, 1'b0);
    rst_n = 1;
    step(); step();

    // Idle gate: EnReq falls at t.
    en = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      $display("idle_gate t+%0d: clk_en=%b block=%b gated=%b err=%b", k, clk_en, block, gated, err);
      chk("idle_block", block, 1'b1);
      chk("idle_clk_en", clk_en, k < 2);
      chk("idle_gated", gated, k >= 10);
      chk("idle_err", err, 1'b0);
    end

    // Wake from OFF with a stray AR at t+5.
    en = 1;
    for (int k = 1; k <= 10; k++) begin
      step();
      idle();
      $display("wake t+%0d: clk_en=%b block=%b gated=%b err=%b", k, clk_en, block, gated, err);
      chk("wake_clk_en", clk_en, 1'b1);
      chk("wake_gated", gated, 1'b0);
      chk("wake_block", block, k < 9);
      chk("wake_err", err, k >= 6);
      if (k == 5) drive(3);
    end
    do_reset();

    // Drain: 2 AR + 3 AW outstanding, then EnReq drops.
    for (int i = 0; i < 5; i++) begin drive(i < 2 ? 3 : 1); step(); end
    idle(); en = 0;
    foreach (drain_seq[i]) begin
      step();
      chk("drain_clk_en_hold", clk_en, 1'b1);
      drive(drain_seq[i]);
      $display("drain slot %0d: code=%0d clk_en=%b block=%b", i, drain_seq[i], clk_en, block);
    end
    step(); idle();
    chk("drain_clk_en_cnt0", clk_en, 1'b1);
    step();
    chk("drain_clk_en_fall", clk_en, 1'b0);
    chk("drain_err", err, 1'b0);
    for (int k = 0; k < 10; k++) step();
    en = 1;
    for (int k = 0; k < 10; k++) step();

    // Abort: one write outstanding, EnReq dips and returns before B.
    drive(1); step(); idle(); en = 0;
    for (int k = 0; k < 3; k++) begin step(); chk("abort_clk_en", clk_en, 1'b1); end
    en = 1;
    step();
    $display("abort: clk_en=%b block=%b", clk_en, block);
    chk("abort_block", block, 1'b0);
    chk("abort_clk_en_on", clk_en, 1'b1);
    drive(2); step(); idle(); step();
    chk("abort_err", err, 1'b0);

    // Saturation with CNT_WIDTH=2.
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(1); step(); end
    idle();
    chk("sat_block", block, 1'b1);
    chk("sat_err_before", err, 1'b0);
    drive(1); step(); idle();
    chk("sat_err", err, 1'b1);
    for (int i = 0; i < 3; i++) begin drive(2); step(); end
    idle();
    $display("saturation: block=%b err=%b", block, err);
    chk("sat_block_clear", block, 1'b0);
    do_reset();
    drive(2); step(); idle();
    chk("underflow_err", err, 1'b1);

    // Reset during GATE_WAIT (err already set by the underflow above).
    en = 0;
    for (int k = 0; k < 4; k++) step();
    rst_n = 0;
    #1;
    $display("reset_mid: clk_en=%b block=%b gated=%b err=%b", clk_en, block, gated, err);
    chk("rstmid_clk_en", clk_en, 1'b1);
    chk("rstmid_block", block, 1'b0);
    chk("rstmid_gated", gated, 1'b0);
    chk("rstmid_err", err, 1'b0);
    en = 1;
    step(); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1); step();
      chk("rstmid_cnt", block, i == 2);
    end
    for (int i = 0; i < 3; i++) begin drive(2); step(); end
    idle();

    // Randomized, protocol-respecting traffic.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      step();
      if ($urandom_range(0, 24) == 0) en = !en;
      aw_r = 1'($urandom_range(0, 1)); aw_v = !m_block() && $urandom_range(0, 2) == 0;
      ar_r = 1'($urandom_range(0, 1)); ar_v = !m_block() && $urandom_range(0, 2) == 0;
      b_r  = 1'($urandom_range(0, 1)); b_v  = m_lvl && m_w > 0 && $urandom_range(0, 2) == 0;
      r_r  = 1'($urandom_range(0, 1)); r_v  = m_lvl && m_r > 0 && $urandom_range(0, 2) == 0;
      r_l  = 1'($urandom_range(0, 1));
    end
    idle();
    $display("random_clean: err=%b", err);

    // Unconstrained traffic with occasional mid-cycle resets.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      step();
      rst_n = 1;
      if ($urandom_range(0, 19) == 0) en = !en;
      {aw_v, aw_r, b_v, b_r} = 4'($urandom);
      {ar_v, ar_r, r_v, r_r, r_l} = 5'($urandom);
      if ($urandom_range(0, 1) == 0) begin aw_v = 0; ar_v = 0; end
      if ($urandom_range(0, 199) == 0) begin #2; rst_n = 0; end
    end
    rst_n = 1; idle();
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
